regfile_xfer_ctrl: RTL and testbench

REGFILE_XFER_CTRL -- requirements
Module: regfile_xfer_ctrl
Block-transfer (LDM/STM) sequencer driving the user/system register file read port C and write port from a 16-bit register list.

---
 rtl/regfile_xfer_ctrl.sv | 139 +++++++++++++
 tb/tb_regfile_xfer_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_xfer_ctrl.sv
// Block-transfer (LDM/STM) sequencer: walks a 16-bit register list in ascending order,
// issuing one memory word transfer per set bit and writing loaded words back to the register file.
module regfile_xfer_ctrl (
    input  logic        clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Load,
    input  logic [15:0] Reg_List,
    input  logic [31:0] Base_Addr,
    output logic        Busy,
    output logic        Done,
    output logic [4:0]  Xfer_Cnt,
    output logic        Mem_Req,
    output logic        Mem_Wr,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData,
    output logic [3:0]  R_Addr_C,
    input  logic [31:0] R_Data_C,
    output logic [3:0]  W_Addr,
    output logic [31:0] W_Data,
    output logic        Write_Reg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        load_q, load_d;
    logic [15:0] list_q, list_d;
    logic [31:0] base_q, base_d;
    logic [4:0]  k_q, k_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [3:0]  cur_reg;
    logic [15:0] list_rest;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = i[3:0];
        end
        return idx;
    endfunction

    assign cur_reg   = lowest_set(list_q);
    // Clearing the lowest set bit leaves the registers still to be transferred.
    assign list_rest = list_q & (list_q - 16'd1);

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        list_d  = list_q;
        base_d  = base_q;
        k_d     = k_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cnt_d = 5'd0;
                    if (Reg_List != 16'd0) begin
                        load_d  = Load;
                        list_d  = Reg_List;
                        base_d  = Base_Addr;
                        k_d     = 5'd0;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (Mem_Ack) begin
                    if (load_q) begin
                        data_d  = Mem_RData;
                        state_d = S_WB;
                    end else begin
                        list_d  = list_rest;
                        k_d     = k_q + 5'd1;
                        cnt_d   = cnt_q + 5'd1;
                        state_d = (list_rest != 16'd0) ? S_REQ : S_DONE;
                    end
                end
            end
            S_WB: begin
                list_d  = list_rest;
                k_d     = k_q + 5'd1;
                cnt_d   = cnt_q + 5'd1;
                state_d = (list_rest != 16'd0) ? S_REQ : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            list_q  <= 16'd0;
            base_q  <= 32'd0;
            k_q     <= 5'd0;
            data_q  <= 32'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            list_q  <= list_d;
            base_q  <= base_d;
            k_q     <= k_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign Xfer_Cnt  = cnt_q;
    assign Mem_Req   = (state_q == S_REQ);
    assign Mem_Wr    = (state_q == S_REQ) & ~load_q;
    // Word offset wraps naturally at 2^32.
    assign Mem_Addr  = base_q + {25'd0, k_q, 2'b00};
    assign Mem_WData = R_Data_C;
    assign R_Addr_C  = cur_reg;
    assign W_Addr    = cur_reg;
    assign W_Data    = data_q;
    assign Write_Reg = (state_q == S_WB);

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Directed bench for regfile_xfer_ctrl: expected memory requests and register writes are
// queued when each command is issued and consumed as the DUT produces them.
module tb_regfile_xfer_ctrl;

    logic        clk;
    logic        Rst;
    logic        Start;
    logic        Load;
    logic [15:0] Reg_List;
    logic [31:0] Base_Addr;
    logic        Busy;
    logic        Done;
    logic [4:0]  Xfer_Cnt;
    logic        Mem_Req;
    logic        Mem_Wr;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;
    logic [3:0]  R_Addr_C;
    logic [31:0] R_Data_C;
    logic [3:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;

    regfile_xfer_ctrl dut (
        .clk(clk), .Rst(Rst), .Start(Start), .Load(Load), .Reg_List(Reg_List),
        .Base_Addr(Base_Addr), .Busy(Busy), .Done(Done), .Xfer_Cnt(Xfer_Cnt),
        .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData), .R_Addr_C(R_Addr_C), .R_Data_C(R_Data_C),
        .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  ra;
        logic [31:0] wd;
    } mem_t;

    typedef struct {
        logic [3:0]  wa;
        logic [31:0] wd;
    } wr_t;

    mem_t        exp_mem[$];
    wr_t         exp_wr[$];
    logic [31:0] rd_q[$];
    int          ack_wait;
    int          tests;
    int          fails;

    // Register file read port model: contents derived from the address.
    assign R_Data_C = 32'hA500_0000 | {28'd0, R_Addr_C};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdv(input logic [3:0] r);
        return 32'hA500_0000 | {28'd0, r};
    endfunction

    task automatic push_mem(input logic [31:0] a, input logic w, input logic [3:0] r);
        mem_t m;
        m.addr = a; m.wr = w; m.ra = r; m.wd = rdv(r);
        exp_mem.push_back(m);
    endtask

    task automatic push_wr(input logic [3:0] r, input logic [31:0] d);
        wr_t e;
        e.wa = r; e.wd = d;
        exp_wr.push_back(e);
        rd_q.push_back(d);
    endtask

    // Memory responder: acknowledges after ack_wait idle request cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        Mem_Ack = 1'b0;
        Mem_RData = 32'd0;
        forever begin
            @(negedge clk);
            if (Mem_Req && Rst) begin
                if (wcnt >= ack_wait) begin
                    Mem_Ack = 1'b1;
                    Mem_RData = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
                    wcnt = 0;
                end else begin
                    Mem_Ack = 1'b0;
                    wcnt++;
                end
            end else begin
                Mem_Ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Scoreboard consumer, sampled on the falling edge.
    initial begin
        mem_t m;
        wr_t  w;
        forever begin
            @(negedge clk);
            #1;
            if (Mem_Req) begin
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_req_addr", Mem_Addr, 32'hXXXX_XXXX);
                end else begin
                    m = exp_mem[0];
                    chk("mem_addr", Mem_Addr, m.addr);
                    chk("mem_wr", {31'd0, Mem_Wr}, {31'd0, m.wr});
                    chk("r_addr_c", {28'd0, R_Addr_C}, {28'd0, m.ra});
                    if (Mem_Ack) begin
                        if (m.wr) chk("mem_wdata", Mem_WData, m.wd);
                        void'(exp_mem.pop_front());
                    end
                end
            end
            if (Write_Reg) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write_reg_addr", {28'd0, W_Addr}, 32'hXXXX_XXXX);
                end else begin
                    w = exp_wr.pop_front();
                    chk("w_addr", {28'd0, W_Addr}, {28'd0, w.wa});
                    chk("w_data", W_Data, w.wd);
                end
            end
        end
    end

    task automatic do_start(input logic ld, input logic [15:0] lst, input logic [31:0] base);
        int b;
        b = 0;
        while (Busy && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        Start = 1'b1; Load = ld; Reg_List = lst; Base_Addr = base;
        @(posedge clk); #1;
        Start = 1'b0; Load = 1'b0; Reg_List = 16'd0; Base_Addr = 32'd0;
    endtask

    task automatic wait_done(input string tag, input int c0, input int exp_cyc);
        int cyc;
        cyc = c0;
        while (!Done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_cyc);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {31'd0, Done}, 32'd0);
        chk({tag, "_idle_after"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0; ack_wait = 0;
        Rst = 1'b0; Start = 1'b0; Load = 1'b0; Reg_List = 16'd0; Base_Addr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_mem_req", {31'd0, Mem_Req}, 32'd0);
        chk("rst_mem_wr", {31'd0, Mem_Wr}, 32'd0);
        chk("rst_write_reg", {31'd0, Write_Reg}, 32'd0);
        chk("rst_xfer_cnt", {27'd0, Xfer_Cnt}, 32'd0);
        chk("rst_mem_addr", Mem_Addr, 32'd0);
        chk("rst_w_addr", {28'd0, W_Addr}, 32'd0);
        chk("rst_w_data", W_Data, 32'd0);
        chk("rst_r_addr_c", {28'd0, R_Addr_C}, 32'd0);
        @(negedge clk);
        Rst = 1'b1;

        // STM r1..r3 from 0x1000, zero-wait memory.
        ack_wait = 0;
        push_mem(32'h1000, 1'b1, 4'd1);
        push_mem(32'h1004, 1'b1, 4'd2);
        push_mem(32'h1008, 1'b1, 4'd3);
        do_start(1'b0, 16'h000E, 32'h1000);
        chk("stm3_busy", {31'd0, Busy}, 32'd1);
        wait_done("stm3", 1, 4);
        chk("stm3_cnt", {27'd0, Xfer_Cnt}, 32'd3);

        // LDM r0 and r15 from 0x2000 with two wait cycles per access.
        ack_wait = 2;
        push_mem(32'h2000, 1'b0, 4'd0);
        push_mem(32'h2004, 1'b0, 4'd15);
        push_wr(4'd0, 32'hAC96_3A55);
        push_wr(4'd15, 32'h1111_1111);
        do_start(1'b1, 16'h8001, 32'h2000);
        wait_done("ldm2", 1, 9);
        chk("ldm2_cnt", {27'd0, Xfer_Cnt}, 32'd2);

        // Empty list completes with no accesses.
        ack_wait = 0;
        do_start(1'b0, 16'h0000, 32'h5555_0000);
        wait_done("empty", 1, 1);
        chk("empty_cnt", {27'd0, Xfer_Cnt}, 32'd0);

        // Address wrap past 2^32.
        push_mem(32'hFFFF_FFFC, 1'b1, 4'd0);
        push_mem(32'h0000_0000, 1'b1, 4'd1);
        do_start(1'b0, 16'h0003, 32'hFFFF_FFFC);
        wait_done("wrap", 1, 3);
        chk("wrap_cnt", {27'd0, Xfer_Cnt}, 32'd2);

        // Reset during the write-back cycle of an LDM drops the pending write.
        push_mem(32'h3000, 1'b0, 4'd1);
        rd_q.push_back(32'h1234_5678);
        do_start(1'b1, 16'h0006, 32'h3000);
        @(posedge clk); #1;
        Rst = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_write_reg", {31'd0, Write_Reg}, 32'd0);
        chk("rstmid_cnt", {27'd0, Xfer_Cnt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        Rst = 1'b1;
        rd_q.delete();
        push_mem(32'h0040, 1'b1, 4'd4);
        do_start(1'b0, 16'h0010, 32'h0040);
        wait_done("post_rst", 1, 2);
        chk("post_rst_cnt", {27'd0, Xfer_Cnt}, 32'd1);

        // Start while busy is ignored.
        ack_wait = 1;
        push_mem(32'h5000, 1'b1, 4'd4);
        push_mem(32'h5004, 1'b1, 4'd5);
        do_start(1'b0, 16'h0030, 32'h5000);
        Start = 1'b1; Load = 1'b1; Reg_List = 16'hFFFF; Base_Addr = 32'h0;
        @(posedge clk); #1;
        Start = 1'b0; Load = 1'b0; Reg_List = 16'd0;
        wait_done("busy_start", 2, 5);
        chk("busy_start_cnt", {27'd0, Xfer_Cnt}, 32'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_mem_drained", exp_mem.size(), 32'd0);
        chk("exp_wr_drained", exp_wr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
